// File: rtl/game_ctl.sv
// game_ctl: duck-hunt round controller (START -> GAME -> SCORE), difficulty ramp, lockout, optional best score
// Ports: clk, rst (sync, active-high); mouse_left raw button level; clicked_duck hit pulse;
//        end_of_time miss pulse; state_out START=00/GAME=10/SCORE=01; time_out seconds per duck;
//        score/misses for the current or last round; best_score built only when HIGH_SCORE_EN is defined.
module game_ctl #(
    parameter logic [7:0]  START_TIME     = 8'd5,
    parameter logic [7:0]  MIN_TIME       = 8'd1,
    parameter logic [7:0]  HITS_PER_LEVEL = 8'd5,
    parameter logic [3:0]  MAX_MISSES     = 4'd3,
    parameter logic [25:0] LOCKOUT_CYCLES = 26'd37_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_left,
    input  logic       clicked_duck,
    input  logic       end_of_time,
    output logic [1:0] state_out,
    output logic [7:0] time_out,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic [7:0] best_score
);
    typedef enum logic [1:0] {START = 2'b00, GAME = 2'b10, SCORE = 2'b01} state_t;
    state_t      state;
    logic        mouse_left_q;
    logic [7:0]  level;
    logic [25:0] lock;
    logic        click;
    logic        round_end;
    assign click     = mouse_left & ~mouse_left_q;
    // a simultaneous hit cancels the miss, so a round can only end on a hit-free cycle
    assign round_end = (state == GAME) & ~clicked_duck & end_of_time & (misses + 4'd1 == MAX_MISSES);
    assign state_out = state;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= START;
            time_out     <= START_TIME;
            score        <= 8'd0;
            misses       <= 4'd0;
            level        <= 8'd0;
            lock         <= 26'd0;
            mouse_left_q <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
            case (state)
                START: if (click) begin
                    state    <= GAME;
                    score    <= 8'd0;
                    misses   <= 4'd0;
                    level    <= 8'd0;
                    time_out <= START_TIME;
                end
                GAME: begin
                    if (clicked_duck) begin
                        score <= (score == 8'hff) ? score : score + 8'd1;
                        if (level + 8'd1 == HITS_PER_LEVEL) begin
                            level    <= 8'd0;
                            time_out <= (time_out > MIN_TIME) ? time_out - 8'd1 : time_out;
                        end else begin
                            level <= level + 8'd1;
                        end
                    end else if (end_of_time) begin
                        misses <= misses + 4'd1;
                        if (round_end) begin
                            state <= SCORE;
                            lock  <= 26'd0;
                        end
                    end
                end
                SCORE: begin
                    if (lock < LOCKOUT_CYCLES - 26'd1) lock <= lock + 26'd1;
                    else if (click) state <= START;
                end
                default: state <= START;
            endcase
        end
    end
`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk) begin
        if (rst) best_score <= 8'd0;
        else if (round_end && score > best_score) best_score <= score;
    end
`else
    assign best_score = 8'd0;
`endif
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed and randomized checks of game_ctl against a round-level reference model
module tb_game_ctl;
    localparam int ST = 5, MT = 1, HPL = 5, MM = 3, LK = 16;
    logic       clk = 1'b0;
    logic       rst, mouse_left, clicked_duck, end_of_time;
    logic [1:0] state_out;
    logic [7:0] time_out, score, best_score;
    logic [3:0] misses;
    int npass = 0, ntot = 0;
    int m_mode, m_hits, m_miss, m_wait, m_best;
    logic m_prev;

    game_ctl #(.LOCKOUT_CYCLES(26'd16)) dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left), .clicked_duck(clicked_duck),
        .end_of_time(end_of_time), .state_out(state_out), .time_out(time_out),
        .score(score), .misses(misses), .best_score(best_score)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] e_state();
        return (m_mode == 1) ? 2'b10 : (m_mode == 2) ? 2'b01 : 2'b00;
    endfunction
    function automatic logic [7:0] e_time();
        int t = ST - m_hits / HPL;
        return 8'((t < MT) ? MT : t);
    endfunction
    function automatic logic [7:0] e_score();
        return 8'((m_hits > 255) ? 255 : m_hits);
    endfunction
    function automatic logic [7:0] e_best();
`ifdef HIGH_SCORE_EN
        return 8'(m_best);
`else
        return 8'd0;
`endif
    endfunction

    // round-level view: modes are "waiting", "playing", "showing score"
    task automatic model(input logic ml, cd, eot, r);
        logic clk_ev;
        if (r) begin
            m_mode = 0; m_hits = 0; m_miss = 0; m_wait = 0; m_best = 0; m_prev = 1'b0;
            return;
        end
        clk_ev = ml && !m_prev;
        m_prev = ml;
        if (m_mode == 0) begin
            if (clk_ev) begin m_mode = 1; m_hits = 0; m_miss = 0; end
        end else if (m_mode == 1) begin
            if (cd) m_hits++;
            else if (eot) begin
                m_miss++;
                if (m_miss == MM) begin
                    m_mode = 2; m_wait = 0;
                    if (e_score() > m_best) m_best = e_score();
                end
            end
        end else begin
            if (m_wait < LK - 1) m_wait++;
            else if (clk_ev) m_mode = 0;
        end
    endtask

    task automatic step(input logic ml, cd, eot, r);
        mouse_left = ml; clicked_duck = cd; end_of_time = eot; rst = r;
        @(posedge clk);
        model(ml, cd, eot, r);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        ntot++; if (state_out !== 2'b00) $display("FAIL reset_state got %b want 00", state_out); else npass++;
        ntot++; if (time_out !== 8'd5) $display("FAIL reset_time got %0d want 5", time_out); else npass++;
        ntot++; if (score !== 8'd0) $display("FAIL reset_score got %0d want 0", score); else npass++;
        ntot++; if (misses !== 4'd0) $display("FAIL reset_misses got %0d want 0", misses); else npass++;
        ntot++; if (best_score !== 8'd0) $display("FAIL reset_best got %0d want 0", best_score); else npass++;
    endtask

    task automatic test_start();
        step(0, 0, 0, 0);
        ntot++; if (state_out !== 2'b00) $display("FAIL idle_state got %b want 00", state_out); else npass++;
        step(1, 0, 0, 0);
        ntot++; if (state_out !== 2'b10) $display("FAIL start_state got %b want 10", state_out); else npass++;
        ntot++; if (time_out !== 8'd5) $display("FAIL start_time got %0d want 5", time_out); else npass++;
        ntot++; if (score !== 8'd0) $display("FAIL start_score got %0d want 0", score); else npass++;
    endtask

    task automatic test_levels();
        for (int i = 1; i <= 30; i++) begin
            step(i[0], 1, 0, 0);
            ntot++; if (score !== 8'(i)) $display("FAIL level_score got %0d want %0d", score, i); else npass++;
            if (i == 5) begin
                ntot++; if (time_out !== 8'd4) $display("FAIL level5_time got %0d want 4", time_out); else npass++;
            end
            if (i == 25 || i == 30) begin
                ntot++; if (time_out !== 8'd1) $display("FAIL level_floor_time got %0d want 1 at hit %0d", time_out, i); else npass++;
            end
        end
        ntot++; if (state_out !== 2'b10) $display("FAIL clicks_in_game got %b want 10", state_out); else npass++;
    endtask

    task automatic test_same_cycle();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        ntot++; if (misses !== 4'd2) $display("FAIL two_misses got %0d want 2", misses); else npass++;
        step(0, 1, 1, 0);
        ntot++; if (score !== 8'd31) $display("FAIL both_score got %0d want 31", score); else npass++;
        ntot++; if (misses !== 4'd2) $display("FAIL both_misses got %0d want 2", misses); else npass++;
        ntot++; if (state_out !== 2'b10) $display("FAIL both_state got %b want 10", state_out); else npass++;
    endtask

    task automatic test_end_round();
        logic [7:0] want;
`ifdef HIGH_SCORE_EN
        want = 8'd31;
`else
        want = 8'd0;
`endif
        step(0, 0, 1, 0);
        ntot++; if (misses !== 4'd3) $display("FAIL end_misses got %0d want 3", misses); else npass++;
        ntot++; if (state_out !== 2'b01) $display("FAIL end_state got %b want 01", state_out); else npass++;
        ntot++; if (best_score !== want) $display("FAIL end_best got %0d want %0d", best_score, want); else npass++;
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        ntot++; if (state_out !== 2'b01) $display("FAIL lockout_click got %b want 01", state_out); else npass++;
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        ntot++; if (state_out !== 2'b01) $display("FAIL lockout_wait got %b want 01", state_out); else npass++;
        step(1, 0, 0, 0);
        ntot++; if (state_out !== 2'b00) $display("FAIL unlock_click got %b want 00", state_out); else npass++;
        ntot++; if (score !== 8'd31) $display("FAIL score_hold got %0d want 31", score); else npass++;
        ntot++; if (misses !== 4'd3) $display("FAIL misses_hold got %0d want 3", misses); else npass++;
    endtask

    task automatic test_mid_rst();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        ntot++; if (score !== 8'd0) $display("FAIL restart_score got %0d want 0", score); else npass++;
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        ntot++; if (score !== 8'd7) $display("FAIL pre_rst_score got %0d want 7", score); else npass++;
        step(1, 1, 1, 1);
        ntot++; if (state_out !== 2'b00) $display("FAIL rst_state got %b want 00", state_out); else npass++;
        ntot++; if (score !== 8'd0) $display("FAIL rst_score got %0d want 0", score); else npass++;
        ntot++; if (misses !== 4'd0) $display("FAIL rst_misses got %0d want 0", misses); else npass++;
        ntot++; if (best_score !== 8'd0) $display("FAIL rst_best got %0d want 0", best_score); else npass++;
        ntot++; if (time_out !== 8'd5) $display("FAIL rst_time got %0d want 5", time_out); else npass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 299) == 0));
            ntot++; if (state_out !== e_state()) $display("FAIL rnd_state cyc %0d got %b want %b", i, state_out, e_state()); else npass++;
            ntot++; if (time_out !== e_time()) $display("FAIL rnd_time cyc %0d got %0d want %0d", i, time_out, e_time()); else npass++;
            ntot++; if (score !== e_score()) $display("FAIL rnd_score cyc %0d got %0d want %0d", i, score, e_score()); else npass++;
            ntot++; if (misses !== 4'(m_miss)) $display("FAIL rnd_misses cyc %0d got %0d want %0d", i, misses, m_miss); else npass++;
            ntot++; if (best_score !== e_best()) $display("FAIL rnd_best cyc %0d got %0d want %0d", i, best_score, e_best()); else npass++;
        end
    endtask

    initial begin
        mouse_left = 0; clicked_duck = 0; end_of_time = 0; rst = 1;
        m_mode = 0; m_hits = 0; m_miss = 0; m_wait = 0; m_best = 0; m_prev = 0;
        test_reset();
        test_start();
        test_levels();
        test_same_cycle();
        test_end_round();
        test_lockout();
        test_mid_rst();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
